// File: rtl/rom_frame_streamer_if.sv
// Avalon-ST source bundle carrying one frame of 32-bit words.
//   tx_data  : word payload
//   tx_valid : source has a beat this cycle
//   tx_ready : sink accepts (readyLatency 0)
//   tx_sop   : first word of the frame
//   tx_eop   : last word of the frame
//   tx_empty : unused bytes in the eop word
// Handshake: a beat transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid is high it stays high, with tx_data/sop/eop/empty frozen,
// until the beat transfers; tx_ready may toggle freely and never depends
// combinationally on tx_valid.
interface rom_frame_streamer_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_empty;

  modport master (
    output tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
    output tx_ready
  );
endinterface

// File: rtl/rom_frame_streamer.sv
// Streams a frame of consecutive ROM words out of an Avalon-ST source.
// A start pulse in IDLE latches base address, length and last-word empty
// count; reads are then issued one per cycle against a fixed-latency ROM,
// tracked by a tag pipeline and landed in a small skip buffer feeding tx.
// Ports:
//   clock, reset_n            : rising-edge clock, async active-low reset
//   start, base_addr,
//   len_words, last_empty     : frame request (sampled on accepted start)
//   busy, done                : frame in progress / one-cycle completion
//   rom_address, rom_q        : ROM read port (ROM_LATENCY cycles)
//   tx                        : Avalon-ST source (master modport)
//   state_dbg, fifo_level     : debug view of FSM state and buffer fill
// FIFO_DEPTH must be at least ROM_LATENCY+2 for back-to-back streaming.
module rom_frame_streamer #(
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [10:0]          base_addr,
  input  logic [10:0]          len_words,
  input  logic [1:0]           last_empty,
  output logic                 busy,
  output logic                 done,
  output logic [10:0]          rom_address,
  input  logic [31:0]          rom_q,
  rom_frame_streamer_if.master tx,
  output logic [1:0]           state_dbg,
  output logic [7:0]           fifo_level
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [10:0]            len_q;
  logic [10:0]            remaining;
  logic [1:0]             last_empty_q;
  logic [ROM_LATENCY-1:0] tag_v, tag_sop, tag_eop;
  logic [31:0]            mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  mem_sop, mem_eop;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          inflight;
  logic                   credit_ok;
  logic                   accept, zero_start, issue;
  logic                   push, pop, eop_accept, head_valid;

  // Reads in flight are counted against the buffer so that every issued
  // read is guaranteed a free slot when its data lands.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CW'(tag_v[i]);
    end
  end

  assign credit_ok  = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign push       = tag_v[ROM_LATENCY-1];
  assign head_valid = (count != '0);
  assign pop        = head_valid && tx.tx_ready;
  assign eop_accept = pop && tx.tx_eop;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    if (issue && remaining == 11'd1) state_nxt = DRAIN;
      DRAIN:   if (eop_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state != IDLE);
    state_dbg  = state;
    accept     = (state == IDLE) && start && (len_words != 11'd0);
    zero_start = (state == IDLE) && start && (len_words == 11'd0);
    issue      = (state == READ) && credit_ok;
  end

  // Frame context and read address; the address holds when nothing issues.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_address  <= '0;
      len_q        <= '0;
      remaining    <= '0;
      last_empty_q <= '0;
      done         <= 1'b0;
    end else begin
      done <= zero_start || eop_accept;
      if (accept) begin
        rom_address  <= base_addr;
        len_q        <= len_words;
        remaining    <= len_words;
        last_empty_q <= last_empty;
      end else if (issue) begin
        rom_address <= rom_address + 11'd1;
        remaining   <= remaining - 11'd1;
      end
    end
  end

  // Tag pipeline: the last stage lines up with rom_q for the same read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v   <= '0;
      tag_sop <= '0;
      tag_eop <= '0;
    end else begin
      tag_v[0]   <= issue;
      tag_sop[0] <= issue && (remaining == len_q);
      tag_eop[0] <= issue && (remaining == 11'd1);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_sop[i] <= tag_sop[i-1];
        tag_eop[i] <= tag_eop[i-1];
      end
    end
  end

  // Buffer storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_q;
      mem_sop[wr_ptr]  <= tag_sop[ROM_LATENCY-1];
      mem_eop[wr_ptr]  <= tag_eop[ROM_LATENCY-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        if (wr_ptr == PW'(FIFO_DEPTH - 1)) wr_ptr <= '0;
        else                               wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        if (rd_ptr == PW'(FIFO_DEPTH - 1)) rd_ptr <= '0;
        else                               rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of the buffer drives tx; everything reads zero while empty.
  always_comb begin
    tx.tx_valid = head_valid;
    tx.tx_data  = '0;
    tx.tx_sop   = 1'b0;
    tx.tx_eop   = 1'b0;
    tx.tx_empty = 2'b00;
    if (head_valid) begin
      tx.tx_data  = mem_data[rd_ptr];
      tx.tx_sop   = mem_sop[rd_ptr];
      tx.tx_eop   = mem_eop[rd_ptr];
      tx.tx_empty = mem_eop[rd_ptr] ? last_empty_q : 2'b00;
    end
  end

  assign fifo_level = 8'(count);

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Bench for rom_frame_streamer: table of frames, hand-built corner
// sequences (ignored start, start in done cycle, reset mid-frame) and
// random frames, all scored against a per-word expected queue.
module tb_rom_frame_streamer;
  localparam int ROM_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;

  typedef struct {
    logic [10:0] base;
    logic [10:0] len;
    logic [1:0]  empty;
    int          mode;       // 0: ready always 1, 1: 30% duty, 2: 50% duty
    int          exp_beats;
    int          exp_lat;    // cycles from accept to first tx_valid, -1 skip
  } vec_t;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] base_addr, len_words;
  logic [1:0]  last_empty;
  logic        busy, done;
  logic [10:0] rom_address;
  logic [31:0] rom_q;
  logic [1:0]  state_dbg;
  logic [7:0]  fifo_level;
  int          cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rom_frame_streamer_if tx_bus ();

  rom_frame_streamer #(
    .ROM_LATENCY (ROM_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .len_words   (len_words),
    .last_empty  (last_empty),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .tx          (tx_bus),
    .state_dbg   (state_dbg),
    .fifo_level  (fifo_level)
  );

  // ROM contents: distinct per address
  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return {a[7:0], ~a[10:3], a, 5'h15};
  endfunction

  // Two-cycle ROM: address register then output register
  logic [10:0] rom_a1;
  always @(posedge clock) begin
    rom_a1 <= rom_address;
    rom_q  <= rom_word(rom_a1);
  end

  // scoreboard
  logic [35:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;
  int beats_seen = 0;
  int done_seen = 0;
  int first_valid_cyc = -1;
  int last_eop_cyc = -1;
  int accept_cyc = 0;
  int ready_mode = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a frame is len consecutive ROM words, address mod 2048
  task automatic model_push(input logic [10:0] b, input logic [10:0] l, input logic [1:0] e);
    for (int i = 0; i < int'(l); i++) begin
      logic [10:0] a;
      logic        last;
      a    = b + 11'(i);
      last = (i == int'(l) - 1);
      exp_q.push_back({rom_word(a), (i == 0), last, last ? e : 2'b00});
    end
  endtask

  // ready driver
  initial begin
    tx_bus.tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       tx_bus.tx_ready = 1'b1;
        1:       tx_bus.tx_ready = ($urandom_range(0, 9) < 3);
        default: tx_bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: beats, stall stability, buffer bound, done pulses
  logic [35:0] cur, held, e;
  bit          prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      cur = {tx_bus.tx_data, tx_bus.tx_sop, tx_bus.tx_eop, tx_bus.tx_empty};
      if (prev_stall)
        check(tx_bus.tx_valid && cur == held, "stall_hold", cur, held);
      if (tx_bus.tx_valid) begin
        check(exp_q.size() != 0, "spurious_valid", 1, 0);
        check(fifo_level <= FIFO_DEPTH, "fifo_level", fifo_level, FIFO_DEPTH);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (tx_bus.tx_valid && tx_bus.tx_ready) begin
        beats_seen++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(cur == e, "beat", cur, e);
        end
        if (tx_bus.tx_eop) last_eop_cyc = cyc;
      end
      if (done) done_seen++;
      prev_stall = tx_bus.tx_valid && !tx_bus.tx_ready;
      held       = cur;
    end
  end

  // driver tasks
  task automatic drive_start(input logic [10:0] b, input logic [10:0] l, input logic [1:0] em);
    start      = 1'b1;
    base_addr  = b;
    len_words  = l;
    last_empty = em;
    first_valid_cyc = -1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(output int at);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clock);
      #1;
      k++;
    end
    check(done == 1'b1, "done_timeout", done, 1);
    at = cyc;
  endtask

  task automatic run_frame(input vec_t v);
    int d0, b0, t;
    @(negedge clock);
    #1;
    ready_mode = v.mode;
    d0 = done_seen;
    b0 = beats_seen;
    model_push(v.base, v.len, v.empty);
    drive_start(v.base, v.len, v.empty);
    @(negedge clock);
    #1;
    check(busy == (v.len != 11'd0), "busy_after_start", busy, v.len != 11'd0);
    wait_done(t);
    check(busy == 1'b0, "busy_at_done", busy, 0);
    if (v.len == 11'd0) begin
      check(t == accept_cyc, "zero_len_done_timing", t - accept_cyc, 0);
      check(first_valid_cyc < 0, "zero_len_no_valid", first_valid_cyc, -1);
    end else begin
      check(t == last_eop_cyc + 1, "done_after_eop", t - last_eop_cyc, 1);
    end
    if (v.exp_lat >= 0)
      check(first_valid_cyc - accept_cyc == v.exp_lat, "first_valid_latency",
            first_valid_cyc - accept_cyc, v.exp_lat);
    if (v.mode == 0 && v.len != 11'd0)
      check(t - first_valid_cyc == int'(v.len), "back_to_back", t - first_valid_cyc, v.len);
    check(beats_seen - b0 == v.exp_beats, "beat_count", beats_seen - b0, v.exp_beats);
    check(exp_q.size() == 0, "all_words_out", exp_q.size(), 0);
    @(negedge clock);
    #1;
    check(done == 1'b0, "done_one_cycle", done, 0);
    check(done_seen - d0 == 1, "done_count", done_seen - d0, 1);
  endtask

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int   t, b0, k;
    vec_t v;
    start = 1'b0; base_addr = '0; len_words = '0; last_empty = '0;
    reset_n = 1'b0;

    vecs[0] = '{11'h010, 11'd4,  2'd2, 0, 4,  3};
    vecs[1] = '{11'h7FE, 11'd4,  2'd0, 0, 4,  3};
    vecs[2] = '{11'h000, 11'd1,  2'd3, 0, 1,  3};
    vecs[3] = '{11'h123, 11'd0,  2'd1, 0, 0,  -1};
    vecs[4] = '{11'h300, 11'd64, 2'd1, 1, 64, -1};
    vecs[5] = '{11'h7F0, 11'd20, 2'd2, 2, 20, -1};
    vecs[6] = '{11'h400, 11'd7,  2'd0, 0, 7,  3};

    // reset state
    repeat (3) @(negedge clock);
    #1;
    check(busy == 1'b0,            "reset_busy",     busy, 0);
    check(done == 1'b0,            "reset_done",     done, 0);
    check(tx_bus.tx_valid == 1'b0, "reset_valid",    tx_bus.tx_valid, 0);
    check(tx_bus.tx_data == '0,    "reset_data",     tx_bus.tx_data, 0);
    check(tx_bus.tx_sop == 1'b0 && tx_bus.tx_eop == 1'b0 && tx_bus.tx_empty == 2'b00,
          "reset_flags", {tx_bus.tx_sop, tx_bus.tx_eop, tx_bus.tx_empty}, 0);
    check(rom_address == '0,       "reset_rom_addr", rom_address, 0);
    reset_n = 1'b1;

    // table of frames
    for (int i = 0; i < NV; i++) run_frame(vecs[i]);

    // second start mid-frame ignored, start in done cycle accepted
    @(negedge clock);
    #1;
    ready_mode = 1;
    b0 = beats_seen;
    model_push(11'h100, 11'd12, 2'd3);
    drive_start(11'h100, 11'd12, 2'd3);
    repeat (4) @(negedge clock);
    #1;
    drive_start(11'h200, 11'd3, 2'd1);
    check(busy == 1'b1, "busy_mid_frame", busy, 1);
    check(rom_address >= 11'h100 && rom_address <= 11'h10C, "ignored_start_addr", rom_address, 11'h100);
    wait_done(t);
    check(beats_seen - b0 == 12, "frame_a_beats", beats_seen - b0, 12);
    b0 = beats_seen;
    model_push(11'h050, 11'd5, 2'd1);
    drive_start(11'h050, 11'd5, 2'd1);
    @(negedge clock);
    #1;
    check(busy == 1'b1, "start_in_done_cycle", busy, 1);
    wait_done(t);
    check(beats_seen - b0 == 5, "frame_b_beats", beats_seen - b0, 5);
    check(exp_q.size() == 0, "frame_b_all_out", exp_q.size(), 0);

    // reset after beat 5 of a 16-word frame
    @(negedge clock);
    #1;
    ready_mode = 0;
    b0 = beats_seen;
    model_push(11'h020, 11'd16, 2'd1);
    drive_start(11'h020, 11'd16, 2'd1);
    k = 0;
    while (beats_seen - b0 < 5 && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    check(beats_seen - b0 == 5, "beats_before_reset", beats_seen - b0, 5);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check(tx_bus.tx_valid == 1'b0, "midreset_valid", tx_bus.tx_valid, 0);
    check(tx_bus.tx_data == '0,    "midreset_data",  tx_bus.tx_data, 0);
    check(tx_bus.tx_sop == 1'b0 && tx_bus.tx_eop == 1'b0 && tx_bus.tx_empty == 2'b00,
          "midreset_flags", {tx_bus.tx_sop, tx_bus.tx_eop, tx_bus.tx_empty}, 0);
    check(busy == 1'b0 && done == 1'b0, "midreset_busy_done", {busy, done}, 0);
    check(rom_address == '0,       "midreset_rom_addr", rom_address, 0);
    check(fifo_level == '0,        "midreset_fifo", fifo_level, 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      #1;
      check(tx_bus.tx_valid == 1'b0 && busy == 1'b0, "quiet_after_reset",
            {tx_bus.tx_valid, busy}, 0);
    end
    v = '{11'h020, 11'd16, 2'd1, 0, 16, 3};
    run_frame(v);

    // random frames
    for (int r = 0; r < 8; r++) begin
      v.base      = 11'($urandom_range(0, 2047));
      v.len       = 11'($urandom_range(1, 40));
      v.empty     = 2'($urandom_range(0, 3));
      v.mode      = int'($urandom_range(0, 2));
      v.exp_beats = int'(v.len);
      v.exp_lat   = (v.mode == 0) ? ROM_LATENCY + 1 : -1;
      run_frame(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/rom_frame_streamer.md
ROM_FRAME_STREAMER -- requirements
Module: rom_frame_streamer

Interface
REQ-001 SHALL have parameter ROM_LATENCY, default 2: cycles from rom_address presented to rom_q valid.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output skid-buffer entries; legal only if FIFO_DEPTH >= ROM_LATENCY+2.
REQ-003 SHALL have port clock  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to stream a frame.
REQ-006 SHALL have port base_addr  in  11  first ROM word address, sampled on accepted start.
REQ-007 SHALL have port len_words  in  11  frame length in 32-bit words, sampled on accepted start.
REQ-008 SHALL have port last_empty  in  2  unused bytes in last word, sampled on accepted start.
REQ-009 SHALL have port busy  out  1  high from accepted start until the frame completes.
REQ-010 SHALL have port done  out  1  one-cycle pulse at frame completion.
REQ-011 SHALL have port rom_address  out  11  ROM read address.
REQ-012 SHALL have port rom_q  in  32  ROM read data.
REQ-013 SHALL have ports tx_data out 32, tx_valid out 1, tx_ready in 1, tx_sop out 1, tx_eop out 1, tx_empty out 2: Avalon-ST source, readyLatency 0.

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN.
REQ-015 IDLE: start=1 with len_words!=0 SHALL latch base_addr/len_words/last_empty, assert busy next cycle, enter READ.
REQ-016 IDLE: start=1 with len_words=0 SHALL produce no tx beat, keep busy low, pulse done next cycle.
REQ-017 start while busy=1 SHALL be ignored, latched values unchanged.
REQ-018 READ: one read per cycle issued only when (words in FIFO + reads in flight) < FIFO_DEPTH; issue = rom_address advances to next word.
REQ-019 rom_address SHALL increment modulo 2048 (0x7FF wraps to 0x000).
REQ-020 Each issued read SHALL be tracked by a ROM_LATENCY-deep valid/sop/eop tag pipeline; rom_q SHALL be written into FIFO exactly ROM_LATENCY cycles after issue.
REQ-021 After len_words reads issued, SHALL enter DRAIN; DRAIN -> IDLE when the eop beat is accepted (tx_valid & tx_ready & tx_eop).
REQ-022 tx_sop SHALL be 1 only on the first word; tx_eop only on word len_words; tx_empty = latched last_empty on eop beat, 0 otherwise.
REQ-023 len_words=1: single beat with tx_sop=tx_eop=1.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data/sop/eop/empty SHALL hold stable; no word SHALL be dropped or duplicated under any ready pattern.
REQ-025 FIFO SHALL never overflow; credit rule REQ-018 guarantees it; simultaneous FIFO write and read SHALL keep count unchanged.
REQ-026 With tx_ready held 1, first tx_valid SHALL occur ROM_LATENCY+1 cycles after start and beats SHALL be back-to-back (one per cycle) until eop.
REQ-027 done SHALL pulse the cycle after the eop beat is accepted; busy SHALL fall in that same cycle; a new start is accepted in that cycle.
REQ-028 rom_address SHALL hold its last value when no read is issued.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, tx_valid=0, tx_sop=0, tx_eop=0, tx_empty=0, tx_data=0, rom_address=0, FIFO empty, tag pipeline cleared.
REQ-030 Reset mid-frame SHALL discard in-flight reads and buffered words; no beat SHALL appear after reset release until a new start.

Verification
REQ-031 start, base_addr=0x010, len_words=4, last_empty=2, tx_ready=1 -> 4 consecutive beats of ROM[0x010..0x013] first at cycle +3, sop on beat 1, eop+empty=2 on beat 4, done 1 cycle later.
REQ-032 base_addr=0x7FE, len_words=4 -> data ROM[0x7FE],ROM[0x7FF],ROM[0x000],ROM[0x001].
REQ-033 len_words=64, tx_ready random 30% duty -> all 64 words in order, stable under stall, FIFO count never > 4, 64 beats exactly.
REQ-034 len_words=0 -> no tx_valid, busy stays 0, done pulses once next cycle.
REQ-035 second start mid-frame with different base_addr -> ignored, first frame output unchanged; start in done cycle -> accepted.
REQ-036 reset_n low after beat 5 of len_words=16 -> outputs zero immediately, no further beats after release, next start streams correctly from sop.
